pc_next_gen: RTL

//  Fetch-side control that drives the PC register: computes next PC, generates PC load enable, runs

---
 rtl/pc_next_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pc_next_gen.sv
// Fetch-side PC control: next-PC select, IMEM request/ack, stall buffering and redirect/flush.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirects go to TRAP_VECTOR).
module pc_next_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_pc_cur,
  output logic [31:0] o_pc_next,
  output logic        o_pc_enable,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_fetch_valid,
  output logic [31:0] o_instr,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_target,
  output logic        o_flush,
  output logic        o_misalign,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: IMEM request holds i_pc_cur stable until i_imem_ack; IF/ID takes o_instr when
  // o_fetch_valid & !i_stall. A redirect always wins over a stall and never waits for it.
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] buf_q;
  logic [31:0] pend_q;
  logic        buf_load;
  logic        pend_load;
  logic [31:0] tgt;
  logic        tgt_misalign;
  logic [31:0] pc_seq;

  assign pc_seq = i_pc_cur + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  assign tgt_misalign = |i_redirect_target[1:0];
  assign tgt          = tgt_misalign ? TRAP_VECTOR : i_redirect_target;
`else
  assign tgt_misalign = 1'b0;
  assign tgt          = i_redirect_target & ~32'h3;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_RESET;
      buf_q   <= 32'h0;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (buf_load)  buf_q  <= i_imem_rdata;
      if (pend_load) pend_q <= tgt;
    end
  end

  always_comb begin
    state_d       = state_q;
    o_pc_next     = pc_seq;
    o_pc_enable   = 1'b0;
    o_imem_req    = 1'b0;
    o_fetch_valid = 1'b0;
    o_instr       = 32'h0;
    o_flush       = 1'b0;
    o_misalign    = 1'b0;
    buf_load      = 1'b0;
    pend_load     = 1'b0;
    case (state_q)
      S_RESET: begin
        o_pc_next = RESET_VECTOR;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        o_imem_req    = 1'b1;
        o_fetch_valid = i_imem_ack;
        o_instr       = i_imem_rdata;
        if (i_redirect_valid) begin
          o_fetch_valid = 1'b0;
          o_flush       = 1'b1;
          o_misalign    = tgt_misalign;
          if (i_imem_ack) begin
            o_pc_next   = tgt;
            o_pc_enable = 1'b1;
          end else begin
            // Fetch address must stay put until the outstanding ack arrives.
            pend_load = 1'b1;
            state_d   = S_DRAIN;
          end
        end else if (i_imem_ack) begin
          if (!i_stall) begin
            o_pc_enable = 1'b1;
          end else begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        o_fetch_valid = 1'b1;
        o_instr       = buf_q;
        if (i_redirect_valid) begin
          o_fetch_valid = 1'b0;
          o_flush       = 1'b1;
          o_misalign    = tgt_misalign;
          o_pc_next     = tgt;
          o_pc_enable   = 1'b1;
          state_d       = S_FETCH;
        end else if (!i_stall) begin
          o_pc_enable = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_DRAIN: begin
        o_imem_req = 1'b1;
        if (i_redirect_valid) begin
          o_flush    = 1'b1;
          o_misalign = tgt_misalign;
          if (i_imem_ack) begin
            o_pc_next   = tgt;
            o_pc_enable = 1'b1;
            state_d     = S_FETCH;
          end else begin
            pend_load = 1'b1;
          end
        end else if (i_imem_ack) begin
          o_pc_next   = pend_q;
          o_pc_enable = 1'b1;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  assign o_dbg_state = state_q;

endmodule
